// File: rtl/rom_arbiter_pkg.sv
// Shared types and helpers for the two-port ROM read arbiter.
// The port id is the payload of the tag FIFO and the value held in last_grant.
package rom_arbiter_pkg;

    typedef enum logic {
        PORT_IFETCH = 1'b0,
        PORT_DLOAD  = 1'b1
    } rom_port_e;

    // last_grant resets to dload so that ifetch wins the first contention.
    localparam rom_port_e LAST_GRANT_RESET = PORT_DLOAD;

    function automatic rom_port_e other_port(input rom_port_e p);
        return (p == PORT_IFETCH) ? PORT_DLOAD : PORT_IFETCH;
    endfunction

    // Pointer width that stays legal when the depth is 1.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/arb_tag_fifo.sv
// Circular FIFO of port ids, one entry per read accepted by the ROM and not yet answered.
// Push while full and pop while empty are ignored; the arbiter never issues either.
module arb_tag_fifo
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  rom_port_e din,
    output rom_port_e dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned      PTR_W     = ptr_width(DEPTH);
    localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    rom_port_e        mem_q [DEPTH];
    rom_port_e        mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);
    assign dout  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every signal gets a default first so no path through the block infers a latch;
        // blocking '=' lets the later statements see the values written above them.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !full;
        do_pop   = pop && !empty;

        if (do_push) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = next_ptr(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = next_ptr(rd_ptr_q);
        end

        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking '<=' so every flop samples the pre-edge values of its peers.
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the entry storage is not reset; count_q alone decides which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/rom_arbiter.sv
// Shares one single-cycle ROM between the ifetch (port 0) and dload (port 1) read hosts.
// Build option ROM_ARB_FIXED_PRIO_EN: dload always wins contention (default round-robin).
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int unsigned PENDING_DEPTH = 2,
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned DATA_W        = 32
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              ifetch_read,
    input  logic [ADDR_W-1:0] ifetch_address,
    output logic              ifetch_waitrequest,
    output logic              ifetch_readdatavalid,
    output logic [DATA_W-1:0] ifetch_agent_to_host,

    input  logic              dload_read,
    input  logic [ADDR_W-1:0] dload_address,
    output logic              dload_waitrequest,
    output logic              dload_readdatavalid,
    output logic [DATA_W-1:0] dload_agent_to_host,

    output logic              rom_read,
    output logic [ADDR_W-1:0] rom_address,
    input  logic              rom_waitrequest,
    input  logic              rom_readdatavalid,
    input  logic [DATA_W-1:0] rom_agent_to_host
);

    rom_port_e winner;
    logic      winner_read;
    logic      accept;
    logic      tag_pop;
    logic      tag_full;
    logic      tag_empty;
    rom_port_e tag_head;

`ifdef ROM_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = dload_read ? PORT_DLOAD : PORT_IFETCH;
    end
`else
    rom_port_e last_grant_q, last_grant_d;

    // Under contention the port that did not win last time goes first.
    always_comb begin
        if (ifetch_read && dload_read) begin
            winner = other_port(last_grant_q);
        end else if (dload_read) begin
            winner = PORT_DLOAD;
        end else begin
            winner = PORT_IFETCH;
        end
    end

    always_comb begin
        last_grant_d = accept ? winner : last_grant_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= LAST_GRANT_RESET;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // rom_read is held low during reset so the ROM never sees a request while the tags are cleared.
    always_comb begin
        winner_read = ifetch_read;
        rom_address = ifetch_address;
        if (winner == PORT_DLOAD) begin
            winner_read = dload_read;
            rom_address = dload_address;
        end

        rom_read = rst && winner_read && !tag_full;
        accept   = rom_read && !rom_waitrequest;

        ifetch_waitrequest = !(accept && (winner == PORT_IFETCH));
        dload_waitrequest  = !(accept && (winner == PORT_DLOAD));

        tag_pop              = rom_readdatavalid && !tag_empty;
        ifetch_readdatavalid = tag_pop && (tag_head == PORT_IFETCH);
        dload_readdatavalid  = tag_pop && (tag_head == PORT_DLOAD);
    end

    assign ifetch_agent_to_host = rom_agent_to_host;
    assign dload_agent_to_host  = rom_agent_to_host;

    arb_tag_fifo #(
        .DEPTH (PENDING_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept),
        .pop   (tag_pop),
        .din   (winner),
        .dout  (tag_head),
        .full  (tag_full),
        .empty (tag_empty)
    );

    // A response with nothing outstanding has no owner and is discarded.
    always_ff @(posedge clk) begin
        if (rst && rom_readdatavalid && tag_empty) begin
            $error("rom_arbiter: readdatavalid with no read outstanding, response dropped");
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench: two arbiters (PENDING_DEPTH 2 and 1) driven by directed and random reads,
// compared against a queue-based reference model with an in-order, variable-latency ROM.
module tb_rom_arbiter;

`ifdef ROM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       i_read, i_wait, i_rdv;
    logic [1:0][31:0] i_addr, i_data;
    logic [1:0]       d_read, d_wait, d_rdv;
    logic [1:0][31:0] d_addr, d_data;
    logic [1:0]       r_read, r_wait, r_rdv;
    logic [1:0][31:0] r_addr, r_data;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        rom_arbiter #(
            .PENDING_DEPTH ((g == 0) ? 2 : 1),
            .ADDR_W        (32),
            .DATA_W        (32)
        ) dut (
            .clk                  (clk),
            .rst                  (rst),
            .ifetch_read          (i_read[g]),
            .ifetch_address       (i_addr[g]),
            .ifetch_waitrequest   (i_wait[g]),
            .ifetch_readdatavalid (i_rdv[g]),
            .ifetch_agent_to_host (i_data[g]),
            .dload_read           (d_read[g]),
            .dload_address        (d_addr[g]),
            .dload_waitrequest    (d_wait[g]),
            .dload_readdatavalid  (d_rdv[g]),
            .dload_agent_to_host  (d_data[g]),
            .rom_read             (r_read[g]),
            .rom_address          (r_addr[g]),
            .rom_waitrequest      (r_wait[g]),
            .rom_readdatavalid    (r_rdv[g]),
            .rom_agent_to_host    (r_data[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: outstanding reads in ROM order as (port, data), plus last granted port.
    int          qport [2][4];
    logic [31:0] qdata [2][4];
    int          qn    [2];
    int          last  [2];
    int          rem_i [2];
    int          rem_d [2];

    int          obs_grant [2];
    bit          acc  [2];
    int          accw [2];
    logic [31:0] acca [2];
    bit          pop  [2];
    bit          rsp_rand  = 1'b0;
    bit          wait_rand = 1'b0;

    function automatic int depth_of(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [31:0] memf(input logic [31:0] a);
        return 32'h5A00_0000 ^ ((a >> 2) * 32'h0001_0203);
    endfunction

    task automatic check_word(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input int k, input logic obs, input logic exp);
        check_word(tag, k, {31'b0, obs}, {31'b0, exp});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            qn[k]   = 0;
            last[k] = 1;
        end
    endtask

    task automatic set_rom(input int k);
        r_rdv[k]  = rst && (qn[k] > 0) && (!rsp_rand || ($urandom_range(0, 9) < 7));
        r_data[k] = r_rdv[k] ? qdata[k][0] : $urandom();
        r_wait[k] = wait_rand && ($urandom_range(0, 3) == 0);
    endtask

    task automatic eval(input int k);
        bit          full, wreq, exp_rr, a, p;
        int          win;
        logic [31:0] waddr;
        obs_grant[k] = (i_wait[k] === 1'b0) ? 0 : ((d_wait[k] === 1'b0) ? 1 : -1);
        acc[k] = 1'b0;
        pop[k] = 1'b0;
        if (!rst) begin
            check_bit("rst_rom_read", k, r_read[k], 1'b0);
            check_bit("rst_i_wait", k, i_wait[k], 1'b1);
            check_bit("rst_d_wait", k, d_wait[k], 1'b1);
            check_bit("rst_i_rdv", k, i_rdv[k], 1'b0);
            check_bit("rst_d_rdv", k, d_rdv[k], 1'b0);
        end else begin
            full = (qn[k] >= depth_of(k));
            if (i_read[k] && d_read[k]) win = FIXED ? 1 : 1 - last[k];
            else                        win = d_read[k] ? 1 : 0;
            wreq   = (win == 1) ? d_read[k] : i_read[k];
            waddr  = (win == 1) ? d_addr[k] : i_addr[k];
            exp_rr = wreq && !full;
            check_bit("rom_read", k, r_read[k], exp_rr);
            if (exp_rr) check_word("rom_address", k, r_addr[k], waddr);
            a = exp_rr && !r_wait[k];
            check_bit("i_wait", k, i_wait[k], !(a && win == 0));
            check_bit("d_wait", k, d_wait[k], !(a && win == 1));
            p = r_rdv[k];
            check_bit("i_rdv", k, i_rdv[k], p && qport[k][0] == 0);
            check_bit("d_rdv", k, d_rdv[k], p && qport[k][0] == 1);
            if (p && qport[k][0] == 0) check_word("i_data", k, i_data[k], qdata[k][0]);
            if (p && qport[k][0] == 1) check_word("d_data", k, d_data[k], qdata[k][0]);
            acc[k]  = a;
            accw[k] = win;
            acca[k] = waddr;
            pop[k]  = p;
        end
    endtask

    task automatic advance(input int k);
        if (rst) begin
            if (pop[k]) begin
                for (int i = 0; i < 3; i++) begin
                    qport[k][i] = qport[k][i+1];
                    qdata[k][i] = qdata[k][i+1];
                end
                qn[k]--;
            end
            if (acc[k]) begin
                qport[k][qn[k]] = accw[k];
                qdata[k][qn[k]] = memf(acca[k]);
                qn[k]++;
                last[k] = accw[k];
            end
        end
        if (i_read[k] && obs_grant[k] == 0) begin
            if (rem_i[k] > 0) begin
                rem_i[k]--;
                i_addr[k] = i_addr[k] + 32'd4;
            end else begin
                i_read[k] = 1'b0;
            end
        end
        if (d_read[k] && obs_grant[k] == 1) begin
            if (rem_d[k] > 0) begin
                rem_d[k]--;
                d_addr[k] = d_addr[k] + 32'd4;
            end else begin
                d_read[k] = 1'b0;
            end
        end
        set_rom(k);
    endtask

    // Inputs change at posedge+1, outputs are checked at posedge+3.
    task automatic tick();
        #2;
        for (int k = 0; k < 2; k++) eval(k);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) advance(k);
    endtask

    task automatic req(input int k, input bit dport, input logic [31:0] addr, input int rem);
        if (dport) begin
            d_read[k] = 1'b1; d_addr[k] = addr; rem_d[k] = rem;
        end else begin
            i_read[k] = 1'b1; i_addr[k] = addr; rem_i[k] = rem;
        end
    endtask

    task automatic drain();
        int budget = 60;
        while ((|i_read || |d_read || qn[0] > 0 || qn[1] > 0) && budget > 0) begin
            tick();
            budget--;
        end
        check_bit("drain_timeout", 0, budget == 0, 1'b0);
    endtask

    task automatic check_grant(input string tag, input int k, input int exp);
        check_word(tag, k, 32'(obs_grant[k]), 32'(exp));
    endtask

    initial begin
        i_read = '0; d_read = '0; i_addr = '0; d_addr = '0;
        r_wait = '0; r_rdv = '0; r_data = '0;
        rem_i = '{0, 0}; rem_d = '{0, 0};
        model_reset();

        // Reset with both ports already requesting.
        for (int k = 0; k < 2; k++) begin
            req(k, 1'b0, 32'h10, 0);
            req(k, 1'b1, 32'h20, 0);
        end
        tick();
        tick();
        rst = 1'b1;

        // Contention right after reset.
        tick();
        for (int k = 0; k < 2; k++) check_grant("first_contention", k, FIXED ? 1 : 0);
        tick();
        check_grant("second_grant", 0, FIXED ? 0 : 1);
        check_grant("full_stall", 1, -1);
        tick();
        check_grant("idle_after_pair", 0, -1);
        check_grant("second_grant", 1, FIXED ? 0 : 1);
        drain();

        // ifetch alone reads 0x0, 0x4, 0x8 back to back.
        for (int k = 0; k < 2; k++) req(k, 1'b0, 32'h0, 2);
        tick();
        check_grant("single_0", 0, 0);
        check_grant("single_0", 1, 0);
        tick();
        check_grant("single_1", 0, 0);
        check_grant("single_1", 1, -1);
        tick();
        check_grant("single_2", 0, 0);
        check_grant("single_2", 1, 0);
        drain();

        // Reset the cycle after a grant, then sustained contention.
        for (int k = 0; k < 2; k++) req(k, 1'b0, 32'h40, 0);
        tick();
        for (int k = 0; k < 2; k++) check_grant("pre_reset_grant", k, 0);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            set_rom(k);
            req(k, 1'b0, 32'h100, 8);
            req(k, 1'b1, 32'h200, 8);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check_grant("rr_depth2", 0, FIXED ? 1 : c % 2);
            check_grant("rr_depth1", 1, (c % 2 == 1) ? -1 : (FIXED ? 1 : (c / 2) % 2));
        end
        rem_i = '{0, 0};
        rem_d = '{0, 0};
        drain();

        // Random traffic with ROM backpressure and delayed responses.
        rsp_rand  = 1'b1;
        wait_rand = 1'b1;
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 2; k++) begin
                if (!i_read[k] && $urandom_range(0, 9) < 6) req(k, 1'b0, 32'($urandom_range(0, 255)) << 2, 0);
                if (!d_read[k] && $urandom_range(0, 9) < 6) req(k, 1'b1, 32'($urandom_range(0, 255)) << 2, 0);
            end
            tick();
        end
        rsp_rand  = 1'b0;
        wait_rand = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
